// File: rtl/bcdu_instr_issue.sv
// BCDU instruction issue queue.
// Buffers sequencer instructions in a circular queue, offers the head to the
// BCDU datapath one at a time, and keeps the compare flags of the last CMP.
module bcdu_instr_issue #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_instr_valid,
    input  logic [15:0]              i_instr,
    output logic                     o_instr_accept,
    output logic                     o_exec_valid,
    output logic [15:0]              o_exec_instr,
    input  logic                     i_exec_ready,
    input  logic                     i_exec_done,
    input  logic                     i_exec_gt,
    input  logic                     i_exec_eq,
    output logic                     o_gt_flag,
    output logic                     o_eq_flag,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_idle,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Opcodes this block needs to recognise; all others pass through untouched.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_CMP = 4'h5;

    localparam logic [LW-1:0] LEVEL_FULL   = LW'(DEPTH);
    localparam logic [LW-1:0] ACCEPT_LIMIT = LW'(DEPTH - 2);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] cmp_cnt_q, cmp_cnt_d;   // CMPs currently sitting in the queue
    logic          inflight_q, inflight_d;
    logic          inflight_cmp_q, inflight_cmp_d;
    logic          gt_q, gt_d;
    logic          eq_q, eq_d;
    logic          ovf_q, ovf_d;

    logic [15:0]   head;
    logic          wr_req, wr_is_cmp, full, exec_valid, pop, head_is_cmp;
    logic          do_wr, retire, cmp_hazard;

    assign head        = mem[rd_ptr_q];
    assign head_is_cmp = (head[15:12] == OP_CMP);
    assign wr_req      = i_instr_valid & (i_instr[15:12] != OP_NOP);
    assign wr_is_cmp   = (i_instr[15:12] == OP_CMP);
    assign full        = (level_q == LEVEL_FULL);
    assign exec_valid  = (level_q != '0) & ~inflight_q;
    assign pop         = exec_valid & i_exec_ready;
    // A full queue still takes a write when the head leaves on the same edge.
    assign do_wr       = wr_req & (~full | pop);
    assign retire      = i_exec_done & inflight_q;
    // Flags are only final once no CMP is waiting or executing.
    assign cmp_hazard  = (cmp_cnt_q != '0) | (inflight_q & inflight_cmp_q);

    // Next-state computation for pointers, occupancy, in-flight tracking and flags.
    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q;
        cmp_cnt_d      = cmp_cnt_q;
        inflight_d     = inflight_q;
        inflight_cmp_d = inflight_cmp_q;
        gt_d           = gt_q;
        eq_d           = eq_q;
        ovf_d          = ovf_q;

        // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);

        case ({do_wr, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        case ({do_wr & wr_is_cmp, pop & head_is_cmp})
            2'b10:   cmp_cnt_d = cmp_cnt_q + LW'(1);
            2'b01:   cmp_cnt_d = cmp_cnt_q - LW'(1);
            default: cmp_cnt_d = cmp_cnt_q;
        endcase

        // Transfer and retire are mutually exclusive: a transfer needs inflight low.
        if (pop) begin
            inflight_d     = 1'b1;
            inflight_cmp_d = head_is_cmp;
        end else if (retire) begin
            inflight_d     = 1'b0;
            inflight_cmp_d = 1'b0;
        end

        if (retire && inflight_cmp_q) begin
            gt_d = i_exec_gt;
            eq_d = i_exec_eq;
        end

        if (wr_req && !do_wr) ovf_d = 1'b1;
    end

    // Control state register with synchronous reset taking priority over all traffic.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            cmp_cnt_q      <= '0;
            inflight_q     <= 1'b0;
            inflight_cmp_q <= 1'b0;
            gt_q           <= 1'b0;
            eq_q           <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            cmp_cnt_q      <= cmp_cnt_d;
            inflight_q     <= inflight_d;
            inflight_cmp_q <= inflight_cmp_d;
            gt_q           <= gt_d;
            eq_q           <= eq_d;
            ovf_q          <= ovf_d;
        end
    end

    // Queue storage write port.
    always_ff @(posedge i_clk) begin
        // NOTE: storage is not reset; a cleared level makes stale entries unreachable.
        if (do_wr && !i_rst) mem[wr_ptr_q] <= i_instr;
    end

    assign o_instr_accept = (level_q <= ACCEPT_LIMIT) & ~cmp_hazard;
    assign o_exec_valid   = exec_valid;
    assign o_exec_instr   = exec_valid ? head : {OP_NOP, 12'b0};
    assign o_gt_flag      = gt_q;
    assign o_eq_flag      = eq_q;
    assign o_level        = level_q;
    assign o_idle         = (level_q == '0) & ~inflight_q;
    assign o_overflow     = ovf_q;

endmodule

// File: doc/bcdu_instr_issue.md
BCDU_INSTR_ISSUE -- requirements
Module: bcdu_instr_issue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction queue depth; legal values are powers of two, minimum 2.
REQ-002 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 i_rst  in  1  reset, synchronous and active-high.
REQ-004 i_instr_valid  in  1  sequencer presents an instruction this cycle.
REQ-005 i_instr  in  16  instruction; [15:12] BCDU opcode (bcdu_op_codes.vh), [11:0] operand fields.
REQ-006 o_instr_accept  out  1  sequencer may present a new instruction in the next cycle.
REQ-007 o_exec_valid  out  1  head instruction offered to the BCDU datapath.
REQ-008 o_exec_instr  out  16  head instruction; {`BCDU_OP_NOP, 12'b0} when o_exec_valid is low.
REQ-009 i_exec_ready  in  1  datapath takes o_exec_instr this cycle.
REQ-010 i_exec_done  in  1  one-cycle pulse: the in-flight instruction has retired.
REQ-011 i_exec_gt, i_exec_eq  in  1 each  compare result; sampled only with i_exec_done.
REQ-012 o_gt_flag, o_eq_flag  out  1 each  flags from the last retired CMP.
REQ-013 o_level  out  $clog2(DEPTH)+1  current queue occupancy.
REQ-014 o_idle  out  1  queue empty and no instruction in flight.
REQ-015 o_overflow  out  1  sticky error: a write was dropped.

Function
REQ-016 The queue SHALL be a circular buffer with registered read and write pointers that wrap modulo DEPTH.
REQ-017 Write rule: i_instr_valid with an opcode other than `BCDU_OP_NOP SHALL enqueue i_instr; NOP instructions SHALL be discarded silently.
REQ-018 Accept rule: o_instr_accept SHALL be combinational and equal (o_level <= DEPTH-2) & ~cmp_hazard; this covers the one-cycle gap between accept and the sequencer's registered valid.
REQ-019 cmp_hazard SHALL be high while any `BCDU_OP_CMP is queued or in flight, so that o_gt_flag/o_eq_flag are final whenever accept is high.
REQ-020 Issue rule: o_exec_valid SHALL equal (o_level != 0) & ~inflight. A transfer is o_exec_valid & i_exec_ready. A transfer SHALL pop the head and set inflight on the next edge.
REQ-021 Latency: an instruction written at edge t SHALL appear on o_exec_valid in the cycle after edge t when the queue was empty and nothing was in flight.
REQ-022 At most one instruction SHALL be in flight. i_exec_done SHALL clear inflight. A new transfer is possible no earlier than the cycle after done.
REQ-023 i_exec_done while inflight is low SHALL be ignored, with no flag update.
REQ-024 On i_exec_done with an in-flight CMP, the block SHALL register o_gt_flag <= i_exec_gt and o_eq_flag <= i_exec_eq on the same edge. Retirement of any other opcode SHALL leave the flags unchanged.
REQ-025 Simultaneous write and pop SHALL leave o_level unchanged. A write while full SHALL be accepted only if a pop occurs in the same cycle.
REQ-026 A write while full with no pop SHALL be dropped: queue contents and pointers unchanged, o_overflow set until reset.
REQ-027 o_idle SHALL equal (o_level == 0) & ~inflight.

Reset
REQ-028 On i_rst the block SHALL clear, on that edge: pointers, o_level=0, inflight=0, o_gt_flag=0, o_eq_flag=0, o_overflow=0. Outputs SHALL then read o_exec_valid=0, o_exec_instr=NOP, o_instr_accept=1, o_idle=1.
REQ-029 Reset mid-operation SHALL discard queued and in-flight instructions. A later i_exec_done SHALL be ignored per REQ-023.
REQ-030 i_rst SHALL take priority over every simultaneous write, transfer and done.

Verification
REQ-031 Write SHL (0x?) at edge t, i_exec_ready=1 -> o_exec_valid=1 in the cycle after t with o_exec_instr equal to the written word; o_level returns to 0 one edge later; o_idle=0 until done.
REQ-032 CMP enqueued -> o_instr_accept=0 until retirement. Done with gt=1, eq=0 -> o_gt_flag=1, o_eq_flag=0 and o_instr_accept=1 after that edge. A following ADD retirement with gt=0 -> o_gt_flag stays 1.
REQ-033 i_exec_ready=0, write 4 SHL/ADD/SUB/CLR with DEPTH=4 -> o_instr_accept=0 from o_level=3. A fifth write -> o_overflow=1, o_level=4. Draining -> instructions issued in order, pointers wrap correctly over 3 refills.
REQ-034 NOP written with valid -> o_level unchanged, o_exec_valid stays 0.
REQ-035 Assert i_rst with 2 queued and 1 in flight, then pulse i_exec_done -> o_level=0, o_idle=1, flags=0, no update.
